mskaes_128bits_state_loader: RTL and testbench



---
 rtl/mskaes_128bits_state_loader.sv | 78 +++++++
 tb/tb_mskaes_128bits_state_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_128bits_state_loader.sv
// Masked AES-128 input stage: collects four 32-bit d-share column words into one 128*d-bit state sharing.
// Optional build macro MSK_LOADER_CLEAR_EN wipes the state register on every output handoff.
module mskaes_128bits_state_loader #(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*d-1:0]    sh_word_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [128*d-1:0]   sh_state_out
);

  localparam int WORD_W = 32 * d;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]        r_state;
  logic [1:0]        r_cnt;
  logic [128*d-1:0]  r_shares;

  logic              w_in_xfer;
  logic              w_out_xfer;

  // Handshakes qualify on registered state only, so outputs never see a combinational input path.
  assign w_in_xfer  = in_valid  && (r_state == S_FILL);
  assign w_out_xfer = out_ready && (r_state == S_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_cnt   <= 2'd0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_state <= S_FILL;
          end
        end
        default: begin
          r_state <= S_FILL;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // NOTE: the share register is reset on purpose: no stale share data may survive a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shares <= '0;
    end else if (w_in_xfer) begin
      // Only the addressed column slice moves; shares are copied verbatim.
      r_shares[int'(r_cnt)*WORD_W +: WORD_W] <= sh_word_in;
`ifdef MSK_LOADER_CLEAR_EN
    end else if (w_out_xfer) begin
      r_shares <= '0;
`endif
    end
  end

  assign in_ready     = (r_state == S_FILL);
  assign out_valid    = (r_state == S_FULL);
  assign sh_state_out = r_shares;

endmodule

// File: tb/tb_mskaes_128bits_state_loader.sv
// Self-checking bench for mskaes_128bits_state_loader (three shares); expectations come from word lists kept here.
module tb_mskaes_128bits_state_loader;

  localparam int D = 3;
  localparam logic [127:0] EXP_B2B =
    128'hCCDDEEFF_8899AABB_44556677_00112233 ^ {128{1'b1}};

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [32*D-1:0]    sh_word_in;
  logic               out_valid;
  logic               out_ready;
  logic [128*D-1:0]   sh_state_out;

  int n_total = 0;
  int n_bad   = 0;

  mskaes_128bits_state_loader #(.d(D)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sh_word_in   (sh_word_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sh_state_out (sh_state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interleave per-share 32-bit words into one sharing: bit i of share j lands at i*D+j.
  function automatic logic [32*D-1:0] pack_word(input logic [31:0] s [D]);
    logic [32*D-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < D; j++)
        r[i*D+j] = s[j][i];
    return r;
  endfunction

  function automatic logic [128*D-1:0] build_state(input logic [32*D-1:0] pw [4]);
    return {pw[3], pw[2], pw[1], pw[0]};
  endfunction

  function automatic logic [127:0] share_of(input logic [128*D-1:0] st, input int j);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = st[i*D+j];
    return r;
  endfunction

  function automatic logic [127:0] xor_shares(input logic [128*D-1:0] st);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = ^st[i*D +: D];
    return r;
  endfunction

  function automatic logic [32*D-1:0] rand_word();
    logic [32*D-1:0] r;
    for (int j = 0; j < D; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sh_word_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [32*D-1:0] w);
    in_valid = 1'b1; sh_word_in = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sh_word_in = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_total++;
    if (sh_state_out !== '0) begin n_bad++; $display("FAIL reset_state: got %h want 0", sh_state_out); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sh_word_in = rand_word();
      out_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid} !== 2'b10 || sh_state_out !== '0) begin
        n_bad++;
        $display("FAIL idle_c%0d: got rdy=%b vld=%b st=%h want rdy=1 vld=0 st=0", c, in_ready, out_valid, sh_state_out);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0]     s [D];
    logic [32*D-1:0] w [8];
    logic [32*D-1:0] pw [4];
    logic [31:0]     col [4];
    int acc, first_acc, fifth_acc;
    logic prev_ready;
    col = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    for (int k = 0; k < 4; k++) begin
      s[0] = col[k];
      s[1] = 32'hFFFF_FFFF;
      for (int j = 2; j < D; j++) s[j] = 32'h0;
      w[k]  = pack_word(s);
      pw[k] = w[k];
    end
    for (int k = 4; k < 8; k++) w[k] = rand_word();
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; sh_word_in = w[0];
    acc = 0; first_acc = -1; fifth_acc = -1;
    prev_ready = in_ready;
    for (int cyc = 1; cyc <= 20 && acc < 5; cyc++) begin
      @(negedge clk);
      if (prev_ready) begin
        acc++;
        if (acc == 1) first_acc = cyc;
        if (acc == 5) fifth_acc = cyc;
        if (acc == 3) begin
          n_total++;
          if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early_valid: got %b want 0", out_valid); end
        end
        if (acc == 4) begin
          n_total++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_full_flags: got vld=%b rdy=%b want vld=1 rdy=0", out_valid, in_ready);
          end
          n_total++;
          if (xor_shares(sh_state_out) !== EXP_B2B) begin
            n_bad++; $display("FAIL b2b_recombined: got %h want %h", xor_shares(sh_state_out), EXP_B2B);
          end
          n_total++;
          if (sh_state_out !== build_state(pw)) begin
            n_bad++; $display("FAIL b2b_sharing: got %h want %h", sh_state_out, build_state(pw));
          end
        end
        if (acc < 8) sh_word_in = w[acc];
      end
      prev_ready = in_ready;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_total++;
    if (fifth_acc - first_acc != 5) begin
      n_bad++; $display("FAIL b2b_throughput: got %0d cycles want 5", fifth_acc - first_acc);
    end
  endtask

  task automatic test_backpressure();
    logic [32*D-1:0] pw [4];
    logic [128*D-1:0] snap;
    bit seen;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      pw[k] = rand_word();
      send_word(pw[k]);
    end
    snap = build_state(pw);
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (!seen) begin n_bad++; $display("FAIL bp_full_timeout: got vld=%b want 1", out_valid); end
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1; sh_word_in = rand_word();
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sh_state_out !== snap) begin
        n_bad++;
        $display("FAIL bp_hold_c%0d: got vld=%b rdy=%b st=%h want vld=1 rdy=0 st=%h", c, out_valid, in_ready, sh_state_out, snap);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_single_xfer: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] g [4][D];
    logic [127:0] exp_sh;
    apply_reset();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < D; j++) g[k][j] = $urandom;
    for (int k = 0; k < 4; k++) begin
      for (int gap = 0; gap < 2; gap++) begin
        sh_word_in = rand_word();
        @(negedge clk);
      end
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL gap_pre_w%0d: got vld=%b rdy=%b want vld=0 rdy=1", k, out_valid, in_ready);
      end
      send_word(pack_word(g[k]));
      sh_word_in = rand_word();
      for (int j = 0; j < D; j++) begin
        exp_sh = '0;
        for (int kk = 0; kk <= k; kk++) exp_sh[32*kk +: 32] = g[kk][j];
        n_total++;
        if (share_of(sh_state_out, j) !== exp_sh) begin
          n_bad++; $display("FAIL gap_w%0d_share%0d: got %h want %h", k, j, share_of(sh_state_out, j), exp_sh);
        end
      end
    end
    n_total++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL gap_full: got %b want 1", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [32*D-1:0] pw [4];
    apply_reset();
    send_word(rand_word());
    send_word(rand_word());
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sh_state_out !== '0) begin
      n_bad++; $display("FAIL rstmid_async: got rdy=%b vld=%b st=%h want rdy=1 vld=0 st=0", in_ready, out_valid, sh_state_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) pw[k] = rand_word();
    send_word(pw[0]);
    n_total++;
    if (sh_state_out !== {{(96*D){1'b0}}, pw[0]}) begin
      n_bad++; $display("FAIL rstmid_word0: got %h want %h", sh_state_out, {{(96*D){1'b0}}, pw[0]});
    end
    for (int k = 1; k < 4; k++) send_word(pw[k]);
    n_total++;
    if (out_valid !== 1'b1 || sh_state_out !== build_state(pw)) begin
      n_bad++; $display("FAIL rstmid_refill: got vld=%b st=%h want vld=1 st=%h", out_valid, sh_state_out, build_state(pw));
    end
  endtask

  task automatic test_clear();
    logic [32*D-1:0] pa [4];
    logic [32*D-1:0] pb [4];
    logic [128*D-1:0] exp_st;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      pa[k] = rand_word();
      send_word(pa[k]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`ifdef MSK_LOADER_CLEAR_EN
    exp_st = '0;
`else
    exp_st = build_state(pa);
`endif
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sh_state_out !== exp_st) begin
      n_bad++; $display("FAIL clr_handoff: got vld=%b rdy=%b st=%h want vld=0 rdy=1 st=%h", out_valid, in_ready, sh_state_out, exp_st);
    end
    pb = pa;
    pb[0] = rand_word();
`ifdef MSK_LOADER_CLEAR_EN
    exp_st = {{(96*D){1'b0}}, pb[0]};
`else
    exp_st = build_state(pb);
`endif
    send_word(pb[0]);
    n_total++;
    if (sh_state_out !== exp_st) begin
      n_bad++; $display("FAIL clr_first_word: got %h want %h", sh_state_out, exp_st);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sh_word_in = '0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
